sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//  Walks a camera register-init table and issues each entry as a 3-phase SCCB write
//  through the SCCB controller (start/done handshake).
//  Supports delay entries, an end marker, and bounded retry on ack error.
//  Sits between the cam2vga top level and the SCCB controller; runs once after power-up
//  and again on each go_i.
// PARAMETERS
//  DEV_ID      8'h42   SCCB device ID driven on sccb_addr_o (bit 0 ignored by controller)
//  TBL_AW      6       table address width; table depth = 2**TBL_AW entries
//  MAX_RETRY   3       retries per entry after the first attempt; 0 = no retry
//  DELAY_TICK  25000   clk_i cycles per delay unit (1 ms at 25 MHz)
//  GAP_CYCLES  64      idle clk_i cycles between transactions and before a retry
// PORTS
//  clk_i             in   1        main clock
//  rst_i             in   1        synchronous reset, active-high
//  go_i              in   1        start sequence; sampled in IDLE/DONE/ERROR only
//  tbl_addr_o        out  TBL_AW   table read address
//  tbl_data_i        in   16       table entry {reg[15:8], val[7:0]}; valid 1 cycle after tbl_addr_o
//  sccb_start_o      out  1        to controller start_i
//  sccb_rw_o         out  1        to controller rw_i; constant 1 (write)
//  sccb_addr_o       out  8        to controller addr_i; constant DEV_ID
//  sccb_data_o       out  16       to controller data_i; latched entry, stable while start high
//  sccb_done_i       in   1        from controller done_o
//  sccb_ack_error_i  in   1        from controller ack_error_o; valid while sccb_done_i = 1
//  busy_o            out  1        sequence in progress
//  done_o            out  1        table completed without fatal error (sticky until next go_i)
//  error_o           out  1        entry failed MAX_RETRY+1 times (sticky until next go_i)
//  err_index_o       out  TBL_AW   index of the failing entry; valid when error_o = 1
// BEHAVIOUR
//  Reset values
//   - All outputs 0, except sccb_rw_o = 1 and sccb_addr_o = DEV_ID.
//   - State is IDLE; retry counter is 0.
//  Entry decode
//   - 16'hFFFF = END.
//   - reg = 8'hFE = DELAY of val*DELAY_TICK cycles; val = 0 means no wait.
//   - Any other entry = WRITE.
//  State machine
//   - IDLE/DONE/ERROR: on go_i, clear done_o/error_o, set index = 0, go to FETCH.
//   - FETCH: drive tbl_addr_o = index; next cycle go to DECODE.
//   - DECODE: latch tbl_data_i and go to END, DELAY or WRITE.
//     - END: go to DONE (done_o = 1, busy_o = 0).
//     - DELAY: load the delay counter, go to DELAY.
//     - WRITE: load sccb_data_o, go to START.
//   - START: sccb_start_o = 1; hold until sccb_done_i = 1, then sample sccb_ack_error_i.
//   - RELEASE: sccb_start_o = 0; stay until sccb_done_i = 0 (controller clears done on its
//     data pulse), then go to GAP.
//   - GAP: wait GAP_CYCLES.
//     - ack ok: index++, retry = 0, go to FETCH.
//     - ack err and retry < MAX_RETRY: retry++, go to START with the same data.
//     - otherwise: go to ERROR (error_o = 1, err_index_o = index).
//   - DELAY: count down to 0, then index++ and go to FETCH.
//  Boundary conditions
//   - Index wrap: completing the entry at 2**TBL_AW-1 without an END entry ends the
//     sequence in DONE; the index never wraps.
//   - go_i while busy_o = 1 is ignored.
//   - sccb_start_o never re-asserts while sccb_done_i = 1.
//   - Reset mid-transaction drops sccb_start_o the same cycle; the controller aborts on start low.
//   - sccb_done_i is ignored outside START/RELEASE.
//   - The delay counter is 8 + clog2(DELAY_TICK) bits wide with no overflow; it saturates at 0.
// STRUCTURE
//  - Shared cam2vga package: state encoding localparams, END_ENTRY = 16'hFFFF,
//    DELAY_REG = 8'hFE.
//  - One sub-module: sccb_seq_timer, a loadable down-counter with zero flag. It is shared by
//    the GAP and DELAY states (load value, enable, zero_o).
//  - The table ROM sits outside this block, so camera-specific tables swap without RTL change.
// TESTING
//  - 3 WRITE entries + END, controller model acks OK -> three transactions with
//    sccb_data_o = 1280, 1100, 3A04 in order; done_o = 1; error_o = 0.
//  - Entry FE05 with DELAY_TICK = 10 -> no sccb_start_o for 50 (+/-2) cycles, then the next entry.
//  - Model NACKs entry 2 twice, MAX_RETRY = 3 -> 3 starts on the same data, then the sequence
//    proceeds; done_o = 1.
//  - Model always NACKs entry 1 -> exactly 4 starts; error_o = 1; err_index_o = 1;
//    busy_o = 0; no further starts.
//  - Model holds done high 200 cycles after start drops -> no new start until done falls,
//    then the GAP elapses, then start.
//  - rst_i asserted mid-START, then go_i -> sccb_start_o = 0 the next cycle; the sequence
//    restarts at index 0; go_i pulses while busy are ignored.

Source files
------------

// File: rtl/sccb_init_sequencer_pkg.sv
// Shared types and constants for the SCCB register-init sequencer.
// State encoding, table entry markers and a small sizing helper.
package sccb_init_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_START,
    ST_RELEASE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  localparam logic [15:0] END_ENTRY = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG = 8'hFE;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sccb_seq_timer.sv
// Loadable down-counter with zero flag; shared by the GAP and DELAY waits.
// Load has priority over enable; the count saturates at zero.
module sccb_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_val_i;
    end else if (en_i && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_o = (count == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks an external register-init table and issues each entry as an SCCB write
// through the controller start/done handshake, with delay entries and bounded retry.
module sccb_init_sequencer
  import sccb_init_sequencer_pkg::*;
#(
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned TBL_AW     = 6,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DELAY_TICK = 25000,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  output logic [TBL_AW-1:0] tbl_addr_o,
  input  logic [15:0]       tbl_data_i,
  output logic              sccb_start_o,
  output logic              sccb_rw_o,
  output logic [7:0]        sccb_addr_o,
  output logic [15:0]       sccb_data_o,
  input  logic              sccb_done_i,
  input  logic              sccb_ack_error_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [TBL_AW-1:0] err_index_o
);

  localparam int unsigned CW = max_u(8 + $clog2(DELAY_TICK), $clog2(GAP_CYCLES + 1));
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t        state_q, state_d;
  logic [TBL_AW-1:0] index_q;
  logic [15:0]       data_q;
  logic [RW-1:0]     retry_q;
  logic              ack_err_q;
  logic              done_q;
  logic              error_q;
  logic [TBL_AW-1:0] err_index_q;

  logic              is_end;
  logic              is_delay;
  logic [7:0]        delay_val;
  logic              last_entry;
  logic              retry_ok;
  logic              go_ok;
  seq_state_t        advance_state;

  logic              timer_load;
  logic              timer_en;
  logic [CW-1:0]     timer_val;
  logic              timer_zero;

  assign is_end        = (tbl_data_i == END_ENTRY);
  assign is_delay      = (tbl_data_i[15:8] == DELAY_REG);
  assign delay_val     = tbl_data_i[7:0];
  assign last_entry    = (index_q == '1);
  assign retry_ok      = (32'(retry_q) < MAX_RETRY);
  assign go_ok         = go_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
  // Completing the last table slot ends the sequence instead of wrapping the index.
  assign advance_state = last_entry ? ST_DONE : ST_FETCH;

  sccb_seq_timer #(
    .W (CW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go_i) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_end) begin
          state_d = ST_DONE;
        end else if (is_delay) begin
          state_d = (delay_val == '0) ? advance_state : ST_DELAY;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sccb_done_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!sccb_done_i) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (!ack_err_q) begin
            state_d = advance_state;
          end else if (retry_ok) begin
            state_d = ST_START;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DELAY: begin
        if (timer_zero) state_d = advance_state;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer is loaded with N-1 on entry so the wait state lasts exactly N cycles.
  always_comb begin
    busy_o     = 1'b1;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    timer_val  = CW'(GAP_CYCLES - 1);
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: busy_o = 1'b0;
      ST_DECODE: begin
        timer_load = is_delay && (delay_val != '0);
        timer_val  = CW'(delay_val) * CW'(DELAY_TICK) - CW'(1);
      end
      ST_RELEASE: timer_load = !sccb_done_i;
      ST_GAP, ST_DELAY: timer_en = 1'b1;
      default: ;
    endcase
  end

  // Start is gated by reset directly so a mid-transaction reset drops it the same cycle.
  assign sccb_start_o = (state_q == ST_START) && !rst_i;
  assign sccb_rw_o    = 1'b1;
  assign sccb_addr_o  = DEV_ID;
  assign sccb_data_o  = data_q;
  assign tbl_addr_o   = index_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_index_o  = err_index_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      index_q     <= '0;
      data_q      <= '0;
      retry_q     <= '0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      if (go_ok) begin
        index_q <= '0;
        retry_q <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if ((state_q == ST_DECODE) && !is_end && !is_delay) begin
        data_q <= tbl_data_i;
      end
      if ((state_q == ST_START) && sccb_done_i) begin
        ack_err_q <= sccb_ack_error_i;
      end
      if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR) &&
          (state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
        index_q <= index_q + TBL_AW'(1);
        retry_q <= '0;
      end
      if ((state_q == ST_GAP) && (state_d == ST_START)) begin
        retry_q <= retry_q + RW'(1);
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
        done_q <= 1'b1;
      end
      if ((state_q != ST_ERROR) && (state_d == ST_ERROR)) begin
        error_q     <= 1'b1;
        err_index_q <= index_q;
      end
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: table ROM, SCCB controller model and a
// table-walking reference model checked against the DUT every cycle.
module tb_sccb_init_sequencer;

  localparam int G    = 8;
  localparam int TICK = 10;
  localparam int MR   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic [2:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        start;
  logic        rw;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        done_i = 1'b0;
  logic        ack_i  = 1'b0;
  logic        busy;
  logic        done_o;
  logic        error_o;
  logic [2:0]  err_index;

  logic [15:0] rom [8];

  int vectors = 0;
  int miscompares = 0;

  int ctl_lat = 5, ctl_hold = 2, ctl_phase = 0, ctl_cnt = 0;
  logic [15:0] nack_data = 16'h0000;
  int nack_cfg = 0, nack_left = 0;
  logic [15:0] got_q [$];

  logic [15:0] exp_q [$];
  int exp_min [$];
  int exp_nd [$];
  logic exp_done, exp_err;
  logic [2:0] exp_err_idx;

  int run_k = 0;
  int idle = 0;
  int idle_log [$];
  logic prev_start = 1'b0;

  sccb_init_sequencer #(
    .DEV_ID     (8'h42),
    .TBL_AW     (3),
    .MAX_RETRY  (MR),
    .DELAY_TICK (TICK),
    .GAP_CYCLES (G)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .go_i             (go),
    .tbl_addr_o       (tbl_addr),
    .tbl_data_i       (tbl_data),
    .sccb_start_o     (start),
    .sccb_rw_o        (rw),
    .sccb_addr_o      (addr),
    .sccb_data_o      (data),
    .sccb_done_i      (done_i),
    .sccb_ack_error_i (ack_i),
    .busy_o           (busy),
    .done_o           (done_o),
    .error_o          (error_o),
    .err_index_o      (err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Controller model: done after ctl_lat cycles, held ctl_hold cycles after start falls.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      done_i = 1'b0; ack_i = 1'b0; ctl_phase = 0; ctl_cnt = 0;
    end else begin
      case (ctl_phase)
        0: if (start) begin got_q.push_back(data); ctl_cnt = ctl_lat; ctl_phase = 1; end
        1: begin
          if (!start) ctl_phase = 0;
          else if (ctl_cnt == 0) begin
            done_i = 1'b1;
            if (data == nack_data && nack_left > 0) begin ack_i = 1'b1; nack_left--; end
            else ack_i = 1'b0;
            ctl_phase = 2;
          end else ctl_cnt--;
        end
        2: if (!start) begin ctl_cnt = ctl_hold; ctl_phase = 3; end
        3: begin
          if (ctl_cnt == 0) begin done_i = 1'b0; ack_i = 1'b0; ctl_phase = 0; end
          else ctl_cnt--;
        end
        default: ctl_phase = 0;
      endcase
    end
  end

  // Reference: walk the table; each write is attempted until acked or retries run out.
  task automatic build_model();
    int pend, nd, nk;
    logic [15:0] e;
    bit stop;
    exp_q.delete(); exp_min.delete(); exp_nd.delete();
    exp_done = 1'b1; exp_err = 1'b0; exp_err_idx = '0;
    pend = 0; nd = 0; stop = 0;
    for (int i = 0; i < 8; i++) begin
      if (!stop) begin
        e = rom[i];
        if (e == 16'hFFFF) stop = 1;
        else if (e[15:8] == 8'hFE) begin pend += int'(e[7:0]) * TICK; nd++; end
        else begin
          nk = (e == nack_data) ? nack_cfg : 0;
          if (nk > MR) begin
            for (int a = 0; a <= MR; a++) begin
              exp_q.push_back(e); exp_min.push_back((a == 0 ? pend : 0) + G); exp_nd.push_back(a == 0 ? nd : 0);
            end
            exp_done = 1'b0; exp_err = 1'b1; exp_err_idx = 3'(i); stop = 1;
          end else begin
            for (int a = 0; a <= nk; a++) begin
              exp_q.push_back(e); exp_min.push_back((a == 0 ? pend : 0) + G); exp_nd.push_back(a == 0 ? nd : 0);
            end
          end
          pend = 0; nd = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0; idle = 0;
    end else begin
      check("rw_const", {31'd0, rw}, 32'd1);
      check("addr_const", {24'd0, addr}, 32'h42);
      if (busy) begin
        check("done_while_busy", {31'd0, done_o}, 32'd0);
        check("error_while_busy", {31'd0, error_o}, 32'd0);
      end
      if (start && !prev_start) begin
        check("start_while_done", {31'd0, done_i}, 32'd0);
        idle_log.push_back(idle);
        if (run_k < exp_q.size()) begin
          check("txn_data", {16'd0, data}, {16'd0, exp_q[run_k]});
          if (run_k > 0)
            check_range("idle_gap", idle, exp_min[run_k], exp_min[run_k] + 5 + 2 * exp_nd[run_k]);
        end else begin
          check("extra_start", run_k, exp_q.size());
        end
        run_k++;
      end else if (start && run_k > 0 && run_k <= exp_q.size()) begin
        check("data_stable", {16'd0, data}, {16'd0, exp_q[run_k-1]});
      end
      if (start) idle = 0;
      else if (!done_i) idle++;
      prev_start = start;
    end
  end

  task automatic run_seq(input int lat, input int hold, input logic [15:0] nd, input int nl, input bit spam);
    int cyc;
    ctl_lat = lat; ctl_hold = hold; nack_data = nd; nack_cfg = nl; nack_left = nl;
    build_model();
    got_q.delete(); idle_log.delete(); run_k = 0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cyc = 0;
    while (busy && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (spam && busy && (cyc % 29) == 0) begin
        go = 1'b1; @(negedge clk); go = 1'b0; cyc++;
      end
    end
    check("timeout_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("n_starts", run_k, exp_q.size());
    check("done_o", {31'd0, done_o}, {31'd0, exp_done});
    check("error_o", {31'd0, error_o}, {31'd0, exp_err});
    if (exp_err) check("err_index", {29'd0, err_index}, {29'd0, exp_err_idx});
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  function automatic int count_got(input logic [15:0] v);
    int n = 0;
    foreach (got_q[i]) if (got_q[i] == v) n++;
    return n;
  endfunction

  task automatic load_basic();
    rom = '{16'h1280, 16'h1100, 16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  endtask

  initial begin
    int cyc, k;
    load_basic();
    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd1);
    check("rst_addr", {24'd0, addr}, 32'h42);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    check("rst_err_index", {29'd0, err_index}, 32'd0);
    check("rst_tbl_addr", {29'd0, tbl_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three writes then END, go pulses while busy.
    run_seq(5, 2, 16'h0000, 0, 1'b1);
    check("t1_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t1_d0", {16'd0, got_q[0]}, 32'h1280);
      check("t1_d1", {16'd0, got_q[1]}, 32'h1100);
      check("t1_d2", {16'd0, got_q[2]}, 32'h3A04);
    end
    check("t1_done", {31'd0, done_o}, 32'd1);

    // Delay entry of 5 units between two writes.
    rom = '{16'h1280, 16'hFE05, 16'h1100, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_seq(5, 2, 16'h0000, 0, 1'b0);
    check("t2_count", got_q.size(), 2);
    if (idle_log.size() >= 2) check_range("t2_delay_idle", idle_log[1], 50 + G, 50 + G + 7);

    // Entry 2 NACKed twice then acked.
    load_basic();
    run_seq(5, 2, 16'h3A04, 2, 1'b0);
    check("t3_retries", count_got(16'h3A04), 3);
    check("t3_done", {31'd0, done_o}, 32'd1);

    // Entry 1 always NACKed.
    run_seq(5, 2, 16'h1100, 1000, 1'b0);
    check("t4_attempts", count_got(16'h1100), 4);
    check("t4_error", {31'd0, error_o}, 32'd1);
    check("t4_err_index", {29'd0, err_index}, 32'd1);
    k = run_k;
    repeat (100) @(negedge clk);
    check("t4_no_more_starts", run_k, k);

    // Controller holds done for 200 cycles after start falls.
    run_seq(5, 200, 16'h0000, 0, 1'b0);
    check("t5_count", got_q.size(), 3);

    // Full table, no END, with a zero-length delay in slot 3.
    rom = '{16'h0101, 16'h0202, 16'h0303, 16'hFE00, 16'h0505, 16'h0606, 16'h0707, 16'h0808};
    run_seq(3, 1, 16'h0000, 0, 1'b0);
    check("t6_count", got_q.size(), 7);
    check("t6_done", {31'd0, done_o}, 32'd1);

    // Reset mid-START, then a fresh run from index 0.
    load_basic();
    build_model();
    got_q.delete(); run_k = 0; ctl_lat = 30; ctl_hold = 2; nack_left = 0; nack_data = 16'h0000;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cyc = 0;
    while (!(start && got_q.size() >= 2) && cyc < 2000) begin @(negedge clk); cyc++; end
    check("t7_reach_start", {31'd0, start}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7_start_drop_now", {31'd0, start}, 32'd0);
    @(negedge clk);
    check("t7_start_drop", {31'd0, start}, 32'd0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_tbl_addr", {29'd0, tbl_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_seq(5, 2, 16'h0000, 0, 1'b1);
    if (got_q.size() > 0) check("t7_restart_d0", {16'd0, got_q[0]}, 32'h1280);
    check("t7_done", {31'd0, done_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
